// File: rtl/pipe_event_monitor_if.sv
// Status bundle between the pipelined CPU / trace consumer and the event monitor.
// master = CPU and trace consumer side, slave = monitor side.
interface pipe_event_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             clear_i;
    logic             stall_i;
    logic             flush_i;
    logic [31:0]      pc_i;
    logic [CNT_W-1:0] cycle_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             done_o;
    logic             trace_valid_o;
    logic [31:0]      trace_pc_o;
    logic             trace_ready_i;
    logic             trace_ovf_o;

    modport master (
        output start_i, clear_i, stall_i, flush_i, pc_i, trace_ready_i,
        input  cycle_o, stall_cnt_o, flush_cnt_o, done_o,
               trace_valid_o, trace_pc_o, trace_ovf_o
    );

    modport slave (
        input  start_i, clear_i, stall_i, flush_i, pc_i, trace_ready_i,
        output cycle_o, stall_cnt_o, flush_cnt_o, done_o,
               trace_valid_o, trace_pc_o, trace_ovf_o
    );
endinterface

// File: rtl/pipe_event_monitor.sv
// Cycle/stall/flush event counters with a cycle budget and a flush-PC trace FIFO.
//   state   | meaning
//   IDLE    | cleared, waiting for start_i
//   RUN     | counting every cycle with start_i high
//   DONE    | budget spent; counters frozen, FIFO still drainable
module pipe_event_monitor #(
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 30,
    parameter int TRACE_DEPTH = 8
) (
    input logic                clk_i,
    input logic                rst_i,
    pipe_event_monitor_if.slave bus
);
    localparam int AW = $clog2(TRACE_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_q [TRACE_DEPTH];

    logic        counting;
    logic        terminal;
    logic [AW:0] fill;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        mem_we;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        counting = bus.start_i && (state_q != ST_DONE);
        // budget_q is the remaining-cycles down-counter; terminal count is the last counted cycle
        terminal = counting && (budget_q == CNT_W'(1));
        fill     = wr_ptr_q - rd_ptr_q;
        empty    = (fill == '0);
        full     = (fill == (AW+1)'(TRACE_DEPTH));
        pop      = !empty && bus.trace_ready_i;
        push_req = counting && bus.flush_i;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        mem_we   = push && !bus.clear_i;

        state_d     = state_q;
        budget_d    = budget_q;
        cycle_d     = cycle_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ovf_d       = ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (bus.clear_i) begin
            state_d     = ST_IDLE;
            budget_d    = CNT_W'(MAX_CYCLES);
            cycle_d     = '0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            ovf_d       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (counting) state_d = terminal ? ST_DONE : ST_RUN;
                ST_RUN:  if (terminal) state_d = ST_DONE;
                default: state_d = ST_DONE;
            endcase
            if (counting) begin
                budget_d = budget_q - CNT_W'(1);
                cycle_d  = sat_inc(cycle_q);
                if (bus.stall_i) stall_cnt_d = sat_inc(stall_cnt_q);
                if (bus.flush_i) flush_cnt_d = sat_inc(flush_cnt_q);
            end
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            budget_q    <= CNT_W'(MAX_CYCLES);
            cycle_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            cycle_q     <= cycle_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= bus.pc_i;
    end

    assign bus.cycle_o       = cycle_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.done_o        = (state_q == ST_DONE);
    assign bus.trace_valid_o = !empty;
    assign bus.trace_pc_o    = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.trace_ovf_o   = ovf_q;
endmodule
